// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding-select codes,
// controller state encoding and the shadow-pipeline destination tag.
package hazard_pkg;

   localparam int HZ_REG_W = 4;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      STALL = 2'b01,
      FLUSH = 2'b10
   } state_e;

   typedef struct packed {
      logic                valid;
      logic [HZ_REG_W-1:0] rd;
      logic                rf_e;
      logic                load;
   } stage_tag_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// fwd_select: picks the forwarding source for one ID operand from the EX/MEM/WB
// shadow tags, youngest producer first. The PC register is never forwarded.
module fwd_select
   import hazard_pkg::*;
#(
   parameter int REG_W  = 4,
   parameter int PC_REG = 15
) (
   input  logic [REG_W-1:0] src,
   input  logic             use_src,
   input  stage_tag_t       ex_tag,
   input  stage_tag_t       mem_tag,
   input  stage_tag_t       wb_tag,
   output logic [1:0]       sel
);

   logic eligible;
   logic hit_ex;
   logic hit_mem;
   logic hit_wb;
   logic unused_load;

   assign eligible    = use_src & (src != REG_W'(PC_REG));
   assign hit_ex      = ex_tag.valid  & ex_tag.rf_e  & (ex_tag.rd  == src);
   assign hit_mem     = mem_tag.valid & mem_tag.rf_e & (mem_tag.rd == src);
   assign hit_wb      = wb_tag.valid  & wb_tag.rf_e  & (wb_tag.rd  == src);
   // Load flag matters only to the hazard detector in the top level.
   assign unused_load = ex_tag.load ^ mem_tag.load ^ wb_tag.load;

   always_comb begin
      sel = FWD_RF;
      if (eligible) begin
         if (hit_ex) begin
            sel = FWD_EX;
         end else if (hit_mem) begin
            sel = FWD_MEM;
         end else if (hit_wb) begin
            sel = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush and operand forwarding control
// for the 5-stage pipeline. Perf counters are built only with HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_W  = 4,
   parameter int PC_REG = 15,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rm,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_use_rn,
   input  logic             id_use_rm,
   input  logic             id_use_rd,
   input  logic             id_rf_e,
   input  logic             id_load,
   input  logic             branch_taken,
   output logic             pc_le,
   output logic             ifid_le,
   output logic             nop_sel,
   output logic             ifid_clr,
   output logic [1:0]       fwd_pa_sel,
   output logic [1:0]       fwd_pb_sel,
   output logic [1:0]       fwd_pd_sel,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   state_e     state_q, state_d;
   stage_tag_t ex_q, ex_d;
   stage_tag_t mem_q, mem_d;
   stage_tag_t wb_q, wb_d;

   logic [1:0] pa_raw;
   logic [1:0] pb_raw;
   logic [1:0] pd_raw;
   logic       load_use;

   fwd_select #(.REG_W(REG_W), .PC_REG(PC_REG)) u_fwd_pa (
      .src     (id_rn),
      .use_src (id_use_rn),
      .ex_tag  (ex_q),
      .mem_tag (mem_q),
      .wb_tag  (wb_q),
      .sel     (pa_raw)
   );

   fwd_select #(.REG_W(REG_W), .PC_REG(PC_REG)) u_fwd_pb (
      .src     (id_rm),
      .use_src (id_use_rm),
      .ex_tag  (ex_q),
      .mem_tag (mem_q),
      .wb_tag  (wb_q),
      .sel     (pb_raw)
   );

   fwd_select #(.REG_W(REG_W), .PC_REG(PC_REG)) u_fwd_pd (
      .src     (id_rd),
      .use_src (id_use_rd),
      .ex_tag  (ex_q),
      .mem_tag (mem_q),
      .wb_tag  (wb_q),
      .sel     (pd_raw)
   );

   // A load in EX can only be consumed once it reaches MEM, so any EX hit on a load stalls.
   assign load_use = ex_q.load & ((pa_raw == FWD_EX) | (pb_raw == FWD_EX) | (pd_raw == FWD_EX));

   always_comb begin
      ex_d.valid = id_valid & ~nop_sel;
      ex_d.rd    = id_rd;
      ex_d.rf_e  = id_rf_e;
      ex_d.load  = id_load;
      mem_d      = ex_q;
      wb_d       = mem_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (load_use) begin
               state_d = STALL;
            end else if (branch_taken) begin
               state_d = FLUSH;
            end
         end
         STALL:   state_d = RUN;
         FLUSH:   state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // The bubble is issued in the detection cycle; STALL is the recovery cycle where
   // the dependent instruction proceeds with the load forwarded from MEM.
   always_comb begin
      pc_le      = 1'b0;
      ifid_le    = 1'b0;
      nop_sel    = 1'b1;
      ifid_clr   = 1'b0;
      fwd_pa_sel = FWD_RF;
      fwd_pb_sel = FWD_RF;
      fwd_pd_sel = FWD_RF;
      if (reset) begin
         fwd_pa_sel = pa_raw;
         fwd_pb_sel = pb_raw;
         fwd_pd_sel = pd_raw;
         case (state_q)
            RUN: begin
               if (!load_use) begin
                  pc_le    = 1'b1;
                  ifid_le  = 1'b1;
                  nop_sel  = ~id_valid;
                  ifid_clr = branch_taken;
               end
            end
            STALL: begin
               pc_le   = 1'b1;
               ifid_le = 1'b1;
               nop_sel = ~id_valid;
            end
            FLUSH: begin
               pc_le   = 1'b1;
               ifid_le = 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (state_q == STALL) begin
         stall_cnt_d = sat_inc(stall_cnt_q);
      end
      if ((state_q == RUN) && (state_d == FLUSH)) begin
         flush_cnt_d = sat_inc(flush_cnt_q);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl: forwarding, load-use stall,
// branch flush, simultaneous events, reset mid-stall and perf counters.
module tb_pipeline_hazard_ctrl;

   logic        clk;
   logic        reset;
   logic        id_valid;
   logic [3:0]  id_rn;
   logic [3:0]  id_rm;
   logic [3:0]  id_rd;
   logic        id_use_rn;
   logic        id_use_rm;
   logic        id_use_rd;
   logic        id_rf_e;
   logic        id_load;
   logic        branch_taken;
   logic        pc_le;
   logic        ifid_le;
   logic        nop_sel;
   logic        ifid_clr;
   logic [1:0]  fwd_pa_sel;
   logic [1:0]  fwd_pb_sel;
   logic [1:0]  fwd_pd_sel;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;
   logic [3:0]  ctl;

   int passed = 0;
   int total  = 0;

   // {pc_le, ifid_le, nop_sel, ifid_clr}
   assign ctl = {pc_le, ifid_le, nop_sel, ifid_clr};

   pipeline_hazard_ctrl #(.REG_W(4), .PC_REG(15), .CNT_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_rn        (id_rn),
      .id_rm        (id_rm),
      .id_rd        (id_rd),
      .id_use_rn    (id_use_rn),
      .id_use_rm    (id_use_rm),
      .id_use_rd    (id_use_rd),
      .id_rf_e      (id_rf_e),
      .id_load      (id_load),
      .branch_taken (branch_taken),
      .pc_le        (pc_le),
      .ifid_le      (ifid_le),
      .nop_sel      (nop_sel),
      .ifid_clr     (ifid_clr),
      .fwd_pa_sel   (fwd_pa_sel),
      .fwd_pb_sel   (fwd_pb_sel),
      .fwd_pd_sel   (fwd_pd_sel),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic issue(input logic v, input logic [3:0] rn, input logic [3:0] rm,
                        input logic [3:0] rd, input logic urn, input logic urm,
                        input logic urd, input logic rfe, input logic ld, input logic br);
      @(posedge clk);
      #1;
      id_valid     = v;
      id_rn        = rn;
      id_rm        = rm;
      id_rd        = rd;
      id_use_rn    = urn;
      id_use_rm    = urm;
      id_use_rd    = urd;
      id_rf_e      = rfe;
      id_load      = ld;
      branch_taken = br;
      #1;
   endtask

   task automatic bubbles(input int n);
      for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      id_valid = 1; id_rn = 1; id_rm = 1; id_rd = 1;
      id_use_rn = 1; id_use_rm = 1; id_use_rd = 1;
      id_rf_e = 1; id_load = 1; branch_taken = 1;
      repeat (2) @(posedge clk);
      #2;
      total++; if (ctl !== 4'b0010) $display("FAIL reset_ctl: got %b want %b", ctl, 4'b0010); else passed++;
      total++; if ({fwd_pa_sel, fwd_pb_sel, fwd_pd_sel} !== 6'b0)
         $display("FAIL reset_fwd: got %b want %b", {fwd_pa_sel, fwd_pb_sel, fwd_pd_sel}, 6'b0); else passed++;
      @(posedge clk);
      #1;
      reset = 1'b1;
      id_valid = 0; id_use_rn = 0; id_use_rm = 0; id_use_rd = 0;
      id_rf_e = 0; id_load = 0; branch_taken = 0;
      #1;
      total++; if (ctl !== 4'b1110) $display("FAIL reset_release_ctl: got %b want %b", ctl, 4'b1110); else passed++;
   endtask

   task automatic test_ex_forward();
      issue(1, 2, 3, 1, 1, 1, 0, 1, 0, 0);     // ADD R1,R2,R3
      total++; if (fwd_pa_sel !== 2'b00) $display("FAIL exfwd_first_pa: got %b want %b", fwd_pa_sel, 2'b00); else passed++;
      issue(1, 1, 5, 4, 1, 1, 0, 1, 0, 0);     // SUB R4,R1,R5
      total++; if (fwd_pa_sel !== 2'b01) $display("FAIL exfwd_pa: got %b want %b", fwd_pa_sel, 2'b01); else passed++;
      total++; if (fwd_pb_sel !== 2'b00) $display("FAIL exfwd_pb: got %b want %b", fwd_pb_sel, 2'b00); else passed++;
      total++; if (ctl !== 4'b1100) $display("FAIL exfwd_ctl: got %b want %b", ctl, 4'b1100); else passed++;
      bubbles(3);
   endtask

   task automatic test_load_use();
      issue(1, 2, 0, 1, 1, 0, 0, 1, 1, 0);     // LDR R1,[R2]
      total++; if (ctl !== 4'b1100) $display("FAIL lu_ldr_ctl: got %b want %b", ctl, 4'b1100); else passed++;
      issue(1, 1, 1, 3, 1, 1, 0, 1, 0, 0);     // ADD R3,R1,R1
      total++; if (ctl !== 4'b0010) $display("FAIL lu_stall_ctl: got %b want %b", ctl, 4'b0010); else passed++;
      issue(1, 1, 1, 3, 1, 1, 0, 1, 0, 0);     // same ADD held in ID
      total++; if (ctl !== 4'b1100) $display("FAIL lu_after_ctl: got %b want %b", ctl, 4'b1100); else passed++;
      total++; if ({fwd_pa_sel, fwd_pb_sel} !== 4'b1010)
         $display("FAIL lu_mem_fwd: got %b want %b", {fwd_pa_sel, fwd_pb_sel}, 4'b1010); else passed++;
      bubbles(3);
   endtask

   task automatic test_priority();
      issue(1, 0, 0, 1, 0, 0, 0, 1, 0, 0);     // MOV R1
      issue(1, 0, 0, 1, 0, 0, 0, 1, 0, 0);     // MOV R1
      issue(1, 0, 1, 2, 1, 1, 0, 1, 0, 0);     // ADD R2,R0,R1
      total++; if (fwd_pb_sel !== 2'b01) $display("FAIL prio_pb: got %b want %b", fwd_pb_sel, 2'b01); else passed++;
      total++; if (fwd_pa_sel !== 2'b00) $display("FAIL prio_pa_r0: got %b want %b", fwd_pa_sel, 2'b00); else passed++;
      issue(1, 3, 0, 2, 1, 0, 1, 0, 0, 0);     // STR R2,[R3]
      total++; if (fwd_pd_sel !== 2'b01) $display("FAIL prio_pd: got %b want %b", fwd_pd_sel, 2'b01); else passed++;
      issue(1, 0, 0, 15, 0, 0, 0, 1, 0, 0);    // MOV R15
      issue(1, 15, 15, 4, 1, 1, 0, 1, 0, 0);   // ADD R4,R15,R15
      total++; if ({fwd_pa_sel, fwd_pb_sel} !== 4'b0000)
         $display("FAIL prio_pc_reg: got %b want %b", {fwd_pa_sel, fwd_pb_sel}, 4'b0000); else passed++;
      bubbles(3);
      issue(1, 0, 0, 5, 0, 0, 0, 1, 0, 0);     // MOV R5
      issue(1, 0, 0, 6, 0, 0, 0, 1, 0, 0);     // MOV R6
      bubbles(1);
      issue(1, 5, 6, 6, 1, 1, 0, 0, 0, 0);     // CMP R5,R6 (Rd not read)
      total++; if ({fwd_pa_sel, fwd_pb_sel} !== 4'b1110)
         $display("FAIL prio_wb_mem: got %b want %b", {fwd_pa_sel, fwd_pb_sel}, 4'b1110); else passed++;
      total++; if (fwd_pd_sel !== 2'b00) $display("FAIL prio_unused_pd: got %b want %b", fwd_pd_sel, 2'b00); else passed++;
      bubbles(3);
   endtask

   task automatic test_branch();
      issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);     // B taken
      total++; if (ctl !== 4'b1101) $display("FAIL br_run_ctl: got %b want %b", ctl, 4'b1101); else passed++;
      issue(1, 0, 0, 7, 0, 0, 0, 1, 0, 1);     // flushed slot, branch asserted again
      total++; if (ctl !== 4'b1110) $display("FAIL br_flush_ctl: got %b want %b", ctl, 4'b1110); else passed++;
      issue(1, 7, 0, 8, 1, 0, 0, 0, 0, 0);     // reads R7 of the squashed slot
      total++; if (ctl !== 4'b1100) $display("FAIL br_back_run: got %b want %b", ctl, 4'b1100); else passed++;
      total++; if (fwd_pa_sel !== 2'b00) $display("FAIL br_nop_tag: got %b want %b", fwd_pa_sel, 2'b00); else passed++;
      issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);     // second taken branch
      total++; if (ctl !== 4'b1101) $display("FAIL br2_run_ctl: got %b want %b", ctl, 4'b1101); else passed++;
      issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (ctl !== 4'b1110) $display("FAIL br2_flush_ctl: got %b want %b", ctl, 4'b1110); else passed++;
      bubbles(3);
   endtask

   task automatic test_load_branch();
      issue(1, 2, 0, 1, 1, 0, 0, 1, 1, 0);     // LDR R1,[R2]
      issue(1, 1, 0, 3, 1, 0, 0, 1, 0, 1);     // ADD R3,R1 with branch_taken
      total++; if (ctl !== 4'b0010) $display("FAIL lb_stall_ctl: got %b want %b", ctl, 4'b0010); else passed++;
      issue(1, 1, 0, 3, 1, 0, 0, 1, 0, 1);     // STALL, branch ignored
      total++; if (ctl !== 4'b1100) $display("FAIL lb_stall_state: got %b want %b", ctl, 4'b1100); else passed++;
      issue(1, 9, 0, 10, 1, 0, 0, 1, 0, 0);
      total++; if (ctl !== 4'b1100) $display("FAIL lb_no_flush: got %b want %b", ctl, 4'b1100); else passed++;
      bubbles(3);
   endtask

   task automatic test_back_to_back_loads();
      issue(1, 2, 0, 1, 1, 0, 0, 1, 1, 0);     // LDR R1,[R2]
      issue(1, 1, 0, 1, 1, 0, 0, 1, 1, 0);     // LDR R1,[R1]
      total++; if (ctl !== 4'b0010) $display("FAIL b2b_stall1: got %b want %b", ctl, 4'b0010); else passed++;
      issue(1, 1, 0, 1, 1, 0, 0, 1, 1, 0);
      total++; if (ctl !== 4'b1100) $display("FAIL b2b_go1: got %b want %b", ctl, 4'b1100); else passed++;
      total++; if (fwd_pa_sel !== 2'b10) $display("FAIL b2b_fwd1: got %b want %b", fwd_pa_sel, 2'b10); else passed++;
      issue(1, 1, 0, 3, 1, 0, 0, 1, 0, 0);     // ADD R3,R1
      total++; if (ctl !== 4'b0010) $display("FAIL b2b_stall2: got %b want %b", ctl, 4'b0010); else passed++;
      issue(1, 1, 0, 3, 1, 0, 0, 1, 0, 0);
      total++; if (ctl !== 4'b1100) $display("FAIL b2b_go2: got %b want %b", ctl, 4'b1100); else passed++;
      total++; if (fwd_pa_sel !== 2'b10) $display("FAIL b2b_fwd2: got %b want %b", fwd_pa_sel, 2'b10); else passed++;
      bubbles(3);
   endtask

   task automatic test_counters();
`ifdef HAZARD_PERF_CNT_EN
      total++; if (stall_cnt !== 16'd4) $display("FAIL cnt_stall: got %0d want %0d", stall_cnt, 4); else passed++;
      total++; if (flush_cnt !== 16'd2) $display("FAIL cnt_flush: got %0d want %0d", flush_cnt, 2); else passed++;
`else
      total++; if (stall_cnt !== 16'd0) $display("FAIL cnt_stall_off: got %0d want %0d", stall_cnt, 0); else passed++;
      total++; if (flush_cnt !== 16'd0) $display("FAIL cnt_flush_off: got %0d want %0d", flush_cnt, 0); else passed++;
`endif
   endtask

   task automatic test_reset_mid_stall();
      issue(1, 2, 0, 1, 1, 0, 0, 1, 1, 0);     // LDR R1,[R2]
      issue(1, 1, 0, 3, 1, 0, 0, 1, 0, 0);     // ADD R3,R1 -> stall
      issue(1, 1, 0, 3, 1, 0, 0, 1, 0, 0);     // STALL state, load in MEM
      total++; if (fwd_pa_sel !== 2'b10) $display("FAIL rms_pre_fwd: got %b want %b", fwd_pa_sel, 2'b10); else passed++;
      reset = 1'b0;
      #1;
      total++; if (ctl !== 4'b0010) $display("FAIL rms_ctl: got %b want %b", ctl, 4'b0010); else passed++;
      total++; if (fwd_pa_sel !== 2'b00) $display("FAIL rms_fwd: got %b want %b", fwd_pa_sel, 2'b00); else passed++;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      total++; if (ctl !== 4'b1100) $display("FAIL rms_release_ctl: got %b want %b", ctl, 4'b1100); else passed++;
      total++; if (fwd_pa_sel !== 2'b00) $display("FAIL rms_release_fwd: got %b want %b", fwd_pa_sel, 2'b00); else passed++;
      total++; if ({stall_cnt, flush_cnt} !== 32'd0)
         $display("FAIL rms_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); else passed++;
   endtask

   initial begin
      test_reset();
      test_ex_forward();
      test_load_use();
      test_priority();
      test_branch();
      test_load_branch();
      test_back_to_back_loads();
      test_counters();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
